// File: rtl/axis_axi_burst_adapter.sv
// AXI-Stream to AXI burst adapter: splits an N-beat stream into INCR bursts
// (max length, no 4 KiB crossing), bounds outstanding bursts.
// Ports: aclk/resetn; s_a* command; s_x* stream in; m_x* data out;
// m_ax* AXI address channel; busy/done status.
module axis_axi_burst_adapter #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_BURST_BEATS = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  s_avalid,
    output logic                  s_aready,
    input  logic [ADDR_WIDTH-1:0] s_aaddr,
    input  logic [ADDR_WIDTH-1:0] s_abeats,
    input  logic                  enableAxiLastSignal,
    input  logic [DATA_WIDTH-1:0] s_xdata,
    input  logic [STRB_WIDTH-1:0] s_xstrb,
    input  logic                  s_xlast,
    input  logic                  s_xvalid,
    output logic                  s_xready,
    output logic [DATA_WIDTH-1:0] m_xdata,
    output logic [STRB_WIDTH-1:0] m_xstrb,
    output logic                  m_xlast,
    output logic                  m_xvalid,
    input  logic                  m_xready,
    output logic [ID_WIDTH-1:0]   m_axid,
    output logic [ADDR_WIDTH-1:0] m_axaddr,
    output logic [7:0]            m_axlen,
    output logic [2:0]            m_axsize,
    output logic [1:0]            m_axburst,
    output logic                  m_axlock,
    output logic [3:0]            m_axcache,
    output logic [2:0]            m_axprot,
    output logic                  m_axvalid,
    input  logic                  m_axready,
    output logic                  busy,
    output logic                  done
);
    localparam int AW    = ADDR_WIDTH;
    localparam int SZ    = $clog2(STRB_WIDTH);
    localparam int PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int DEPTH = 1 << PW;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t r_state, w_next;

    logic          r_live;
    logic          r_mode;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_rem;
    logic [AW-1:0] r_in_left;
    logic [AW-1:0] r_in_cnt;
    logic          r_pushed;
    logic [8:0]    r_len_q [DEPTH];
    logic [PW:0]   r_wr_ptr, r_rd_ptr, r_in_ptr;

    logic                  r_mvalid, r_mlast, r_mend, r_mfinal;
    logic [DATA_WIDTH-1:0] r_mdata;
    logic [STRB_WIDTH-1:0] r_mstrb;
    logic                  r_svalid, r_slast, r_send, r_sfinal;
    logic [DATA_WIDTH-1:0] r_sdata;
    logic [STRB_WIDTH-1:0] r_sstrb;

    logic          w_accept, w_full, w_axvalid, w_push, w_aw_hs;
    logic [PW:0]   w_count;
    logic [12:0]   w_space;
    logic [AW-1:0] w_len_full;
    logic [8:0]    w_len, w_head;
    logic          w_in_avail, w_in_end, w_in_final, w_in_last;
    logic          w_in_acc, w_out_acc, w_pop, w_final_hs;
    logic          w_unused;

    assign w_accept = s_avalid && s_aready;
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_full   = (w_count == (PW+1)'(MAX_OUTSTANDING));

    // Beats left before the next 4 KiB page.
    assign w_space = (13'd4096 - {1'b0, r_addr[11:0]}) >> SZ;

    always_comb begin
        w_len_full = r_rem;
        if (w_len_full > AW'(MAX_BURST_BEATS))
            w_len_full = AW'(MAX_BURST_BEATS);
        if (w_len_full > AW'(w_space))
            w_len_full = AW'(w_space);
    end
    assign w_len = w_len_full[8:0];

    // Length is pushed once when the burst first appears; r_pushed keeps
    // m_axvalid held even if that push filled the FIFO.
    assign w_axvalid = (r_state == RUN) && (r_rem != '0)
                     && (r_pushed || !w_full);
    assign w_push    = w_axvalid && !r_pushed;
    assign w_aw_hs   = w_axvalid && m_axready;

    // The input side walks the FIFO with its own pointer, since up to two
    // beats can sit in the output and skid registers ahead of the pop.
    assign w_in_avail = (r_in_ptr != r_wr_ptr);
    assign w_head     = r_len_q[r_in_ptr[PW-1:0]];
    assign w_in_end   = ((r_in_cnt + 1'b1) == AW'(w_head));
    assign w_in_final = (r_in_left == AW'(1));
    assign w_in_last  = w_in_final || (w_in_end && r_mode);

    assign s_xready   = (r_state == RUN) && w_in_avail && !r_svalid;
    assign w_in_acc   = s_xvalid && s_xready;
    assign w_out_acc  = r_mvalid && m_xready;
    assign w_pop      = w_out_acc && r_mend;
    assign w_final_hs = w_out_acc && r_mfinal;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)
                         w_next = (s_abeats == '0) ? FINISH : RUN;
            RUN:     if (w_final_hs) w_next = FINISH;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_live    <= 1'b0;
            r_mode    <= 1'b0;
            r_addr    <= '0;
            r_rem     <= '0;
            r_in_left <= '0;
            r_in_cnt  <= '0;
            r_pushed  <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_in_ptr  <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_addr    <= s_aaddr & ~AW'(STRB_WIDTH - 1);
                r_rem     <= s_abeats;
                r_in_left <= s_abeats;
                r_mode    <= enableAxiLastSignal;
                r_in_cnt  <= '0;
                r_pushed  <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_pushed <= 1'b1;
            end
            if (w_aw_hs) begin
                r_addr   <= r_addr + (w_len_full << SZ);
                r_rem    <= r_rem - w_len_full;
                r_pushed <= 1'b0;
            end
            if (w_in_acc) begin
                r_in_left <= r_in_left - 1'b1;
                if (w_in_end) begin
                    r_in_cnt <= '0;
                    r_in_ptr <= r_in_ptr + 1'b1;
                end else begin
                    r_in_cnt <= r_in_cnt + 1'b1;
                end
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push)
            r_len_q[r_wr_ptr[PW-1:0]] <= w_len;
    end

    // Output register with a one-entry skid buffer behind it.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_mvalid <= 1'b0;
            r_mlast  <= 1'b0;
            r_mend   <= 1'b0;
            r_mfinal <= 1'b0;
            r_mdata  <= '0;
            r_mstrb  <= '0;
            r_svalid <= 1'b0;
            r_slast  <= 1'b0;
            r_send   <= 1'b0;
            r_sfinal <= 1'b0;
            r_sdata  <= '0;
            r_sstrb  <= '0;
        end else if (!r_mvalid || m_xready) begin
            if (r_svalid) begin
                r_mvalid <= 1'b1;
                r_mdata  <= r_sdata;
                r_mstrb  <= r_sstrb;
                r_mlast  <= r_slast;
                r_mend   <= r_send;
                r_mfinal <= r_sfinal;
                r_svalid <= 1'b0;
            end else if (w_in_acc) begin
                r_mvalid <= 1'b1;
                r_mdata  <= s_xdata;
                r_mstrb  <= s_xstrb;
                r_mlast  <= w_in_last;
                r_mend   <= w_in_end;
                r_mfinal <= w_in_final;
            end else begin
                r_mvalid <= 1'b0;
                r_mlast  <= 1'b0;
            end
        end else if (w_in_acc) begin
            r_svalid <= 1'b1;
            r_sdata  <= s_xdata;
            r_sstrb  <= s_xstrb;
            r_slast  <= w_in_last;
            r_send   <= w_in_end;
            r_sfinal <= w_in_final;
        end
    end

    assign s_aready  = r_live && (r_state == IDLE);
    assign busy      = (r_state == RUN);
    assign done      = (r_state == FINISH);

    assign m_xdata   = r_mdata;
    assign m_xstrb   = r_mstrb;
    assign m_xlast   = r_mlast;
    assign m_xvalid  = r_mvalid;

    assign m_axid    = '0;
    assign m_axaddr  = r_addr;
    assign m_axlen   = w_len_full[7:0] - 8'd1;
    assign m_axsize  = 3'(SZ);
    assign m_axburst = 2'b01;
    assign m_axlock  = 1'b0;
    assign m_axcache = 4'b0011;
    assign m_axprot  = 3'b000;
    assign m_axvalid = w_axvalid;

    assign w_unused = ^{s_xlast, w_len_full[AW-1:9]};
endmodule

// File: doc/axis_axi_burst_adapter.md
# axis_axi_burst_adapter

Bridges an AXI Stream transfer of N beats to an AXI memory port. It splits the stream into INCR bursts of configurable maximum length, never lets a burst cross a 4 KiB boundary, and bounds how many bursts can be outstanding. It sits between the stream producers (rasterizer, framebuffer, DMA) and the AXI interconnect. It is a superset of the current fixed-16-beat adapter and contains its own address generator.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width in bits (power of 2, ≥ 8).
- ADDR_WIDTH, 32, address and beat-count width.
- STRB_WIDTH, DATA_WIDTH/8, strobe width.
- ID_WIDTH, 8, AXI ID width.
- MAX_BURST_BEATS, 16, maximum beats per burst (power of 2, 1..256).
- MAX_OUTSTANDING, 4, maximum bursts presented but not yet fully streamed (power of 2, ≥ 1).

Ports:
- aclk  in  1  clock; one clock domain. Reset is asynchronous and active-low.
- resetn  in  1  asynchronous active-low reset.
- s_avalid / s_aready  in/out  1  command handshake.
- s_aaddr  in  ADDR_WIDTH  start byte address. The low $clog2(STRB_WIDTH) bits are forced to 0.
- s_abeats  in  ADDR_WIDTH  total beats in the command; 0 is legal.
- enableAxiLastSignal  in  1  1: m_xlast on every burst end. 0: m_xlast only on the final beat. Sampled at command accept.
- s_xdata, s_xstrb, s_xlast, s_xvalid / s_xready  in/out  stream input. s_xlast is ignored.
- m_xdata, m_xstrb, m_xlast, m_xvalid / m_xready  out/in  stream/AXI data output.
- m_axid (const 0), m_axaddr, m_axlen[7:0], m_axsize[2:0] (= $clog2(STRB_WIDTH)), m_axburst (= 2'b01), m_axlock (0), m_axcache (4'b0011), m_axprot (0), m_axvalid / m_axready  AXI address channel.
- busy  out  1  high from command accept until the last data beat is accepted.
- done  out  1  one-cycle pulse after the last data beat is accepted.

## Operation
- **FSM states:** IDLE, RUN, FINISH.
- **IDLE:**
  - s_aready = 1.
  - On s_avalid, latch address, beat count and mode, then go to RUN.
  - If s_abeats == 0, go directly to FINISH.
- **Address generator (RUN):**
  - Burst length L = min(remaining, MAX_BURST_BEATS, (4096 − addr[11:0]) / STRB_WIDTH).
  - Present m_axaddr = addr and m_axlen = L−1.
  - At presentation, push L into the length FIFO (depth MAX_OUTSTANDING).
  - Hold m_axvalid until m_axready. Then addr += L·STRB_WIDTH and remaining −= L.
  - No new burst is presented while the FIFO is full.
- **Data path:**
  - s_xready = 1 only in RUN, while the FIFO is non-empty and the skid buffer is free.
  - Accepted beats pass through a one-entry skid buffer into registered m_x* outputs.
  - A beat counter per burst is compared against the FIFO head.
  - On the head-count beat, m_xlast = enableAxiLastSignal; the FIFO pops when that beat is accepted downstream.
  - On the overall final beat, m_xlast = 1 regardless of mode.
- **RUN → FINISH:** when the final beat is accepted on m_x (m_xvalid && m_xready).
- **FINISH:** done = 1 for one cycle, then go to IDLE.
- **Widths:** remaining and the counters are ADDR_WIDTH wide. Address wraps modulo 2^ADDR_WIDTH.
- **Reset:** asserting resetn at any time, including mid-burst, aborts the transfer. All state goes to IDLE and the FIFO empties. The AXI slave is expected to be reset with the adapter.

## Timing
- **Reset values:** s_aready=0 during reset and 1 on the first cycle after. s_xready=0, m_xvalid=0, m_xlast=0, m_axvalid=0, busy=0, done=0. Data and address registers are don't-care.
- **Command to first address:** command accepted at cycle T; m_axvalid=1 at T+1; s_xready may first be 1 at T+2.
- **Data latency:** s_x→m_x is 1 cycle. Sustained throughput is 1 beat/cycle when m_xready=1.
- **Back-pressure:**
  - When m_xready=0 with m_xvalid=1, one extra beat is absorbed into the skid buffer.
  - s_xready drops the next cycle. No beat is lost or duplicated.
- **Address channel:**
  - Bursts are back-to-back, one per cycle when m_axready=1 and the FIFO has space.
  - m_axaddr and m_axlen stay stable while m_axvalid && !m_axready.
- **Simultaneous events:** a FIFO push and pop in the same cycle leave the occupancy unchanged. A pop on the cycle the FIFO is full frees space for a presentation the next cycle.
- **Completion:** done asserts on the cycle after the final m_x handshake; busy falls in the same cycle. s_aready returns 1 one cycle later.

## Test plan
- **Burst splitting:** addr 0x1000, 40 beats, DATA_WIDTH 32, MAX 16, m_xready=m_axready=1.
  - Bursts are (0x1000,len 15), (0x1040,15), (0x1080,7).
  - m_xlast on beats 16, 32, 40; done once.
- **Stream mode:** same command with enableAxiLastSignal=0. m_xlast only on beat 40; the burst sequence is unchanged.
- **4 KiB boundary:** addr 0x0FF8, 8 beats. Bursts are (0x0FF8,len 1) and (0x1000,len 5); m_xlast on beats 2 and 8.
- **Outstanding limit:** 128 beats with m_xready=0 and m_axready=1.
  - Exactly 4 bursts are presented, then m_axvalid stays 0.
  - After m_xready=1, the remaining 4 bursts follow.
- **Random back-pressure:** 1000 beats of incrementing data with random m_xready, s_xvalid and m_axready.
  - Output equals input with no loss or duplication.
  - Per-burst beat counts equal m_axlen+1.
- **Edge cases:**
  - 0 beats gives no AXI traffic and done at T+1.
  - Reset at beat 20 of 40 clears all outputs to their reset values; a new 8-beat command then completes normally.
